alu_exec_stage: RTL and testbench

- Registered execute stage directly downstream of the ALU-control decoder.
- Consumes the 3-bit ALU control code plus two operands and computes result and zero flag.
- Presents the outcome to the memory/writeback side over a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready a pure register output, so backpressure never forms a combinational path back into decode.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_exec_stage_core.sv | 34 +++
 rtl/alu_exec_stage.sv | 155 +++++++++++++++
 tb/tb_alu_exec_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-stage payload layout, imported by the
// ALU-control decoder and the execute stage.
package alu_pkg;

  localparam int ALU_CTRL_W = 3;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b101;

  localparam int EXEC_DATA_W = 32;
  localparam int EXEC_ADDR_W = 5;

  // Payload at the default widths; the stage rebuilds it for its own parameters.
  typedef struct packed {
    logic [EXEC_DATA_W-1:0] result;
    logic                   zero;
    logic [EXEC_ADDR_W-1:0] rd_addr;
    logic                   reg_write;
    logic                   illegal;
  } exec_payload_t;

endpackage

// File: rtl/alu_exec_stage_core.sv
// Combinational ALU: maps a control code and two operands to a result and an
// illegal-code flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [ALU_CTRL_W-1:0] alu_control,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  illegal
);

  logic signed [DATA_WIDTH-1:0] a_s;
  logic signed [DATA_WIDTH-1:0] b_s;

  assign a_s = src_a;
  assign b_s = src_b;

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (alu_control)
      ALU_ADD: result = src_a + src_b;
      ALU_SUB: result = src_a - src_b;
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_SLT: result = {{(DATA_WIDTH-1){1'b0}}, (a_s < b_s)};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a 2-entry skid buffer so in_ready is a
// pure flop output and downstream backpressure never reaches decode combinationally.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ALU_CTRL_W-1:0]     alu_control,
  input  logic [DATA_WIDTH-1:0]     src_a,
  input  logic [DATA_WIDTH-1:0]     src_b,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic                      reg_write,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_result,
  output logic                      out_zero,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
  output logic                      out_reg_write,
  output logic                      out_illegal
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     result;
    logic                      zero;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      reg_write;
    logic                      illegal;
  } payload_t;

  // State is the concatenation {main valid, skid valid}.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_TWO   = 2'b11;

  function automatic logic is_zero(input logic [DATA_WIDTH-1:0] value);
    return (value == '0);
  endfunction

  logic [DATA_WIDTH-1:0] core_result;
  logic                  core_illegal;
  payload_t              in_p0;
  payload_t              main_p1;
  payload_t              skid_p1;
  logic                  vld_p1;
  logic                  skid_vld_p1;
  logic                  in_ready_p1;
  logic                  vld_nxt;
  logic                  skid_vld_nxt;
  logic                  load_main_in;
  logic                  load_main_skid;
  logic                  load_skid;
  logic                  accept;
  logic                  xfer;

  // ---- Stage p0: compute at the input side ----
  alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .alu_control(alu_control),
    .src_a      (src_a),
    .src_b      (src_b),
    .result     (core_result),
    .illegal    (core_illegal)
  );

  always_comb begin
    in_p0.result    = core_result;
    in_p0.zero      = is_zero(core_result);
    in_p0.rd_addr   = rd_addr;
    in_p0.reg_write = reg_write;
    in_p0.illegal   = core_illegal;
  end

  assign accept = in_valid && in_ready_p1;
  assign xfer   = vld_p1 && out_ready;

  always_comb begin
    vld_nxt        = vld_p1;
    skid_vld_nxt   = skid_vld_p1;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      vld_nxt      = 1'b0;
      skid_vld_nxt = 1'b0;
    end else begin
      case ({vld_p1, skid_vld_p1})
        ST_EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            vld_nxt      = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && xfer) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid    = 1'b1;
            skid_vld_nxt = 1'b1;
          end else if (xfer) begin
            vld_nxt = 1'b0;
          end
        end
        ST_TWO: begin
          if (xfer) begin
            load_main_skid = 1'b1;
            skid_vld_nxt   = 1'b0;
          end
        end
        default: begin
          vld_nxt      = 1'b0;
          skid_vld_nxt = 1'b0;
        end
      endcase
    end
  end

  // ---- Stage p1: main and skid registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      in_ready_p1 <= 1'b1;
      main_p1     <= '0;
      skid_p1     <= '0;
    end else begin
      vld_p1      <= vld_nxt;
      skid_vld_p1 <= skid_vld_nxt;
      in_ready_p1 <= !skid_vld_nxt;
      if (load_main_in) begin
        main_p1 <= in_p0;
      end else if (load_main_skid) begin
        main_p1 <= skid_p1;
      end
      if (load_skid) begin
        skid_p1 <= in_p0;
      end else if (load_main_skid) begin
        skid_p1 <= '0;
      end
    end
  end

  assign in_ready      = in_ready_p1;
  assign out_valid     = vld_p1;
  assign out_result    = main_p1.result;
  assign out_zero      = main_p1.zero;
  assign out_rd_addr   = main_p1.rd_addr;
  assign out_reg_write = main_p1.reg_write;
  assign out_illegal   = main_p1.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: table-driven op vectors, a FIFO scoreboard on the
// output handshake, and hand-written backpressure, flush and reset sequences.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write;
  logic        out_illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_control  (alu_control),
    .src_a        (src_a),
    .src_b        (src_b),
    .rd_addr      (rd_addr),
    .reg_write    (reg_write),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_rd_addr  (out_rd_addr),
    .out_reg_write(out_reg_write),
    .out_illegal  (out_illegal)
  );

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_ill;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t tbl[10];

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 input logic rw);
    exp_t e;
    e.rd  = rd;
    e.rw  = rw;
    e.ill = 1'b0;
    case (op)
      3'b000:  e.result = a + b;
      3'b001:  e.result = a - b;
      3'b010:  e.result = a & b;
      3'b011:  e.result = a | b;
      3'b101:  e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin
        e.result = 32'd0;
        e.ill    = 1'b1;
      end
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: transfers pop before same-cycle accepts push.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_output actual=%0h required=none", out_result);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_result", out_result, mon_e.result);
          chk("sb_zero", {31'd0, out_zero}, {31'd0, mon_e.zero});
          chk("sb_rd", {27'd0, out_rd_addr}, {27'd0, mon_e.rd});
          chk("sb_rw", {31'd0, out_reg_write}, {31'd0, mon_e.rw});
          chk("sb_ill", {31'd0, out_illegal}, {31'd0, mon_e.ill});
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready)
        sb_q.push_back(model(alu_control, src_a, src_b, rd_addr, reg_write));
    end
  end

  task automatic wait_hs(input string name);
    int  n;
    bit  hs;
    n  = 0;
    hs = 1'b0;
    do begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 20);
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout actual=0 required=1", name);
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic rw);
    alu_control = op;
    src_a       = a;
    src_b       = b;
    rd_addr     = rd;
    reg_write   = rw;
    in_valid    = 1'b1;
    wait_hs("send");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_result"}, out_result, 32'd0);
    chk({tag, "_zero"}, {31'd0, out_zero}, 32'd0);
    chk({tag, "_rd"}, {27'd0, out_rd_addr}, 32'd0);
    chk({tag, "_rw"}, {31'd0, out_reg_write}, 32'd0);
    chk({tag, "_ill"}, {31'd0, out_illegal}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{3'b000, 32'd5,        32'd7,        5'd3,  1'b1, 32'd12,     1'b0, 1'b0};
    tbl[1] = '{3'b001, 32'd3,        32'd3,        5'd4,  1'b1, 32'd0,      1'b1, 1'b0};
    tbl[2] = '{3'b000, 32'hFFFFFFFF, 32'd1,        5'd5,  1'b0, 32'd0,      1'b1, 1'b0};
    tbl[3] = '{3'b101, 32'hFFFFFFFF, 32'd1,        5'd6,  1'b1, 32'd1,      1'b0, 1'b0};
    tbl[4] = '{3'b101, 32'h7FFFFFFF, 32'h80000000, 5'd7,  1'b1, 32'd0,      1'b1, 1'b0};
    tbl[5] = '{3'b010, 32'h0000F0F0, 32'h0000FF00, 5'd8,  1'b1, 32'h0000F000, 1'b0, 1'b0};
    tbl[6] = '{3'b011, 32'h00000F00, 32'h000000F0, 5'd9,  1'b0, 32'h00000FF0, 1'b0, 1'b0};
    tbl[7] = '{3'b111, 32'd9,        32'd4,        5'd10, 1'b1, 32'd0,      1'b1, 1'b1};
    tbl[8] = '{3'b100, 32'd1,        32'd2,        5'd11, 1'b1, 32'd0,      1'b1, 1'b1};
    tbl[9] = '{3'b110, 32'd8,        32'd8,        5'd31, 1'b1, 32'd0,      1'b1, 1'b1};

    rst         = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    alu_control = 3'b000;
    src_a       = '0;
    src_b       = '0;
    rd_addr     = '0;
    reg_write   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Table vectors with the output always ready: one-cycle latency each.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].rw);
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_result", i), out_result, tbl[i].exp_result);
      chk($sformatf("vec%0d_zero", i), {31'd0, out_zero}, {31'd0, tbl[i].exp_zero});
      chk($sformatf("vec%0d_ill", i), {31'd0, out_illegal}, {31'd0, tbl[i].exp_ill});
      chk($sformatf("vec%0d_rd", i), {27'd0, out_rd_addr}, {27'd0, tbl[i].rd});
      chk($sformatf("vec%0d_rw", i), {31'd0, out_reg_write}, {31'd0, tbl[i].rw});
    end
    @(posedge clk);
    #1;
    chk("vec_drain_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: fill main and skid, third input held upstream.
    out_ready = 1'b0;
    send(3'b000, 32'd1, 32'd1, 5'd1, 1'b1);
    chk("bp_ready_after_first", {31'd0, in_ready}, 32'd1);
    send(3'b000, 32'd2, 32'd2, 5'd2, 1'b1);
    chk("bp_ready_after_second", {31'd0, in_ready}, 32'd0);
    alu_control = 3'b000;
    src_a       = 32'd3;
    src_b       = 32'd3;
    rd_addr     = 5'd3;
    reg_write   = 1'b1;
    in_valid    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_stall_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_stall_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_stall_result", out_result, 32'd2);
    chk("bp_stall_rd", {27'd0, out_rd_addr}, 32'd1);
    out_ready = 1'b1;
    wait_hs("bp_third");
    chk("bp_third_result", out_result, 32'd6);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_queue_drained", sb_q.size(), 32'd0);
    chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);

    // Flush in state TWO drops held entries and the input offered that cycle.
    out_ready = 1'b0;
    send(3'b000, 32'd10, 32'd0, 5'd12, 1'b1);
    send(3'b000, 32'd20, 32'd0, 5'd13, 1'b1);
    chk("fl_two_ready", {31'd0, in_ready}, 32'd0);
    flush       = 1'b1;
    in_valid    = 1'b1;
    src_a       = 32'd100;
    src_b       = 32'd0;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("fl_stays_empty", {31'd0, out_valid}, 32'd0);
    send(3'b000, 32'd5, 32'd5, 5'd14, 1'b0);
    chk("fl_resume_result", out_result, 32'd10);
    @(posedge clk);
    #1;

    // Illegal code, then reset with both entries occupied.
    out_ready = 1'b0;
    send(3'b111, 32'd9, 32'd4, 5'd7, 1'b1);
    chk("ill_result", out_result, 32'd0);
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
    chk("ill_zero", {31'd0, out_zero}, 32'd1);
    send(3'b000, 32'd1, 32'd2, 5'd8, 1'b1);
    chk("rst_two_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_outputs("midrst");
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_stays_empty", {31'd0, out_valid}, 32'd0);
    chk("final_queue_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
